// File: rtl/imem_load_arbiter.sv
// -----------------------------------------------------------------------------
// imem_load_arbiter
//
// Shares a byte-addressed, big-endian instruction memory between the CPU
// fetch port and a program-loader port. In IDLE the memory address follows
// fetch_pc and the fetched word is returned combinationally. An accepted
// loader word is written as four byte writes (WR0..WR3), with the MSB going
// to the lowest address. Fetch is stalled while those writes are in progress.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   fetch_req/pc        fetch request and byte address
//   fetch_instr/valid   fetched word (0 when not valid) and its valid flag
//   fetch_stall         request present but memory busy writing
//   ld_valid/addr/data  loader word offer (big-endian data)
//   ld_ready            loader handshake ready
//   ld_err              1-cycle pulse: accepted word misaligned/out of range
//   busy                write sequence in progress
//   mem_addr/rdata      memory byte address and combinational read word
//   mem_we/wdata        byte write enable and write byte
//
// Optional feature (macro IMEM_WRITE_COUNT_EN):
//   adds output words_written[15:0], the saturating count of completed words.
// -----------------------------------------------------------------------------
module imem_load_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic [31:0]       fetch_instr,
    output logic              fetch_valid,
    output logic              fetch_stall,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic              ld_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
`ifdef IMEM_WRITE_COUNT_EN
    output logic [15:0]       words_written,
`endif
    output logic [7:0]        mem_wdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR0,
        ST_WR1,
        ST_WR2,
        ST_WR3
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST_BASE = ADDR_W'(MEM_BYTES - 4);

    state_t            r_state;
    logic [ADDR_W-1:0] r_waddr;   // current write byte address
    logic [31:0]       r_data;    // shifts left one byte per write; MSB is the byte being written
    logic              r_err;
    logic              r_we;
    logic              r_busy;
`ifdef IMEM_WRITE_COUNT_EN
    logic [15:0]       r_count;
`endif

    logic w_idle;
    logic w_bad_addr;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_bad_addr = (ld_addr[1:0] != 2'b00) || (ld_addr > LP_LAST_BASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_waddr <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
`ifdef IMEM_WRITE_COUNT_EN
            r_count <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_err   <= 1'b0;
                    r_waddr <= ld_addr;
                    r_data  <= ld_data;
                    // ld_ready is 1 whenever IDLE and out of reset, so ld_valid alone means accept
                    if (ld_valid) begin
                        if (w_bad_addr) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= ST_WR0;
                            r_we    <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_WR0, ST_WR1, ST_WR2: begin
                    r_state <= (r_state == ST_WR0) ? ST_WR1 :
                               (r_state == ST_WR1) ? ST_WR2 : ST_WR3;
                    r_waddr <= r_waddr + 1'b1;
                    r_data  <= {r_data[23:0], 8'h00};
                end
                ST_WR3: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
`ifdef IMEM_WRITE_COUNT_EN
                    if (r_count != 16'hFFFF) begin
                        r_count <= r_count + 16'd1;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates the handshake and the write strobe in the same cycle, so a
    // sequence aborted by reset never writes the byte of the aborted cycle.
    assign ld_ready    = w_idle & ~reset;
    assign fetch_valid = w_idle & fetch_req & ~reset;
    assign fetch_stall = ~w_idle & fetch_req & ~reset;
    assign fetch_instr = fetch_valid ? mem_rdata : '0;
    assign mem_addr    = w_idle ? fetch_pc : r_waddr;
    assign mem_we      = r_we & ~reset;
    assign mem_wdata   = r_data[31:24];
    assign ld_err      = r_err;
    assign busy        = r_busy;
`ifdef IMEM_WRITE_COUNT_EN
    assign words_written = r_count;
`endif

endmodule
